// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::SERIAL_SUB_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start_valid, a, b, done_ready,
    input  start_ready, done_valid, diff, borrow, busy, ovf
  );

  modport slave (
    input  start_valid, a, b, done_ready,
    output start_ready, done_valid, diff, borrow, busy, ovf
  );
`else
  modport master (
    output start_valid, a, b, done_ready,
    input  start_ready, done_valid, diff, borrow, busy
  );

  modport slave (
    input  start_valid, a, b, done_ready,
    output start_ready, done_valid, diff, borrow, busy
  );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: x - y - bin.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow out when y exceeds x, or they are equal and a borrow came in.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH RUN cycles,
// one full_subtractor cell plus a registered borrow.
// Optional macro SERIAL_SUB_OVF_EN registers a signed-overflow flag.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state and datapath updates: load on accept, shift one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = RUN;
          sa_d    = bus.a;
          sb_d    = bus.b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        br_d  = cell_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit sa_q[0]/sb_q[0] are the operand sign bits.
          ovf_d   = (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ cell_d);
`endif
        end
      end
      DONE: begin
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake and result outputs come straight from registers.
  always_comb begin
    bus.start_ready = (state_q == IDLE);
    bus.busy        = (state_q == RUN);
    bus.done_valid  = (state_q == DONE);
    bus.diff        = res_q;
    bus.borrow      = br_q;
`ifdef SERIAL_SUB_OVF_EN
    bus.ovf         = ovf_q;
`endif
  end

endmodule
